// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Imported by the picker and the arbiter top.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {IDLE, OWNED} arb_state_t;

    typedef logic [1:0] req_id_t;

    function automatic logic [N_REQ-1:0] id2onehot(req_id_t id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/or4.sv
// Four-input OR gate, the shared primitive used for request summaries.
module or4 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_y
);

    assign o_y = i_a | i_b | i_c | i_d;

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request at or after start,
// optionally skipping one index.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_id_t          start,
    input  logic             exclude_en,
    input  req_id_t          exclude_id,
    output logic             found,
    output req_id_t          id
);

    req_id_t w_idx;

    always_comb begin
        found = 1'b0;
        id    = '0;
        w_idx = start;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = start + req_id_t'(k);
            if (!found && req[w_idx] &&
                !(exclude_en && (w_idx == exclude_id))) begin
                found = 1'b1;
                id    = w_idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant
// and a bounded hold time before a contested owner is preempted.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       grant_id,
    output logic             grant_valid,
    output logic             any_req
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t       r_state;
    req_id_t          r_ptr;
    logic [HW-1:0]    r_hold;
    logic [N_REQ-1:0] r_grant;
    req_id_t          r_grant_id;
    logic             r_grant_valid;

    arb_state_t       w_state_nxt;
    req_id_t          w_ptr_nxt;
    logic [HW-1:0]    w_hold_nxt;
    req_id_t          w_id_nxt;
    logic [N_REQ-1:0] w_grant_nxt;
    logic             w_valid_nxt;
    logic             w_take;
    logic             w_owner_req;
    logic             w_contested;
    req_id_t          w_start;
    logic             w_found;
    req_id_t          w_win;

    or4 u_any (
        .i_a (req[0]),
        .i_b (req[1]),
        .i_c (req[2]),
        .i_d (req[3]),
        .o_y (any_req)
    );

    assign w_owner_req = req[r_grant_id];
    // A still-requesting owner is only ever displaced by someone else.
    assign w_contested = (r_state == OWNED) && w_owner_req;
    assign w_start     = w_contested ? r_grant_id + 2'd1 : r_ptr;

    rr_pick4 u_pick (
        .req        (req),
        .start      (w_start),
        .exclude_en (w_contested),
        .exclude_id (r_grant_id),
        .found      (w_found),
        .id         (w_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_hold        <= '0;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_hold        <= w_hold_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_id_nxt;
            r_grant_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_id_nxt    = r_grant_id;
        w_take      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_take = w_found;
            end
            OWNED: begin
                if (!w_owner_req) begin
                    if (w_found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_id_nxt    = '0;
                        w_hold_nxt  = '0;
                    end
                end else if (r_hold < HOLD_LAST) begin
                    w_hold_nxt = r_hold + HW'(1);
                end else begin
                    // Saturated: keep counter at the limit until a rival shows up.
                    w_take = w_found;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_take) begin
            w_state_nxt = OWNED;
            w_id_nxt    = w_win;
            w_ptr_nxt   = w_win + 2'd1;
            w_hold_nxt  = '0;
        end
    end

    always_comb begin
        w_valid_nxt = (w_state_nxt == OWNED);
        w_grant_nxt = '0;
        if (w_valid_nxt) begin
            w_grant_nxt = id2onehot(w_id_nxt);
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4 (MAX_HOLD=8 and MAX_HOLD=1 instances).
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] grant0, grant1;
    logic [1:0] id0, id1;
    logic       v0, v1, any0, any1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant0),
        .grant_id    (id0),
        .grant_valid (v0),
        .any_req     (any0)
    );

    rr_arbiter4 #(.MAX_HOLD(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant1),
        .grant_id    (id1),
        .grant_valid (v1),
        .any_req     (any1)
    );

    int m_own [2];
    int m_ptr [2];
    int m_hold[2];
    int m_max [2] = '{8, 1};

    function automatic int scan(logic [3:0] r, int start, int excl);
        for (int k = 0; k < 4; k++) begin
            int idx = (start + k) % 4;
            if (idx != excl && r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        @(posedge clk);
        #1;
        checks++;
        if (grant0 !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grant got %b want 0000", grant0);
        end
        checks++;
        if (id0 !== 2'd0) begin
            errors++;
            $display("FAIL reset_id got %0d want 0", id0);
        end
        checks++;
        if (v0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", v0);
        end
    endtask

    task automatic test_any_req_sweep();
        for (int v = 0; v < 16; v++) begin
            req = 4'(v);
            #1;
            checks++;
            if (any0 !== (v != 0) || any1 !== (v != 0)) begin
                errors++;
                $display("FAIL any_req req=%b got %b/%b want %b",
                         req, any0, any1, (v != 0));
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        tick(4'b0100);
        tick(4'b0100);
        checks++;
        if (grant0 !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_pre got %b want 0100", grant0);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant0 !== 4'b0000 || v0 !== 1'b0 || id0 !== 2'd0) begin
            errors++;
            $display("FAIL midrst_async got g=%b v=%b id=%0d want 0/0/0",
                     grant0, v0, id0);
        end
        req = 4'b1000;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (grant0 !== 4'b1000 || id0 !== 2'd3 || v0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after got g=%b id=%0d v=%b want 1000/3/1",
                     grant0, id0, v0);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int         exp [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(seq[i]);
            checks++;
            if (id0 !== 2'(exp[i]) || v0 !== 1'b1 ||
                grant0 !== 4'(1 << exp[i])) begin
                errors++;
                $display("FAIL rr_step%0d got id=%0d g=%b v=%b want id=%0d",
                         i, id0, grant0, v0, exp[i]);
            end
        end
    endtask

    task automatic test_preemption();
        do_reset();
        for (int t = 1; t <= 24; t++) begin
            tick(4'b0011);
            checks++;
            if (id0 !== 2'(((t - 1) / 8) % 2) || v0 !== 1'b1) begin
                errors++;
                $display("FAIL preempt8 t=%0d got id=%0d v=%b want %0d",
                         t, id0, v0, ((t - 1) / 8) % 2);
            end
            checks++;
            if (id1 !== 2'((t - 1) % 2) || v1 !== 1'b1) begin
                errors++;
                $display("FAIL preempt1 t=%0d got id=%0d v=%b want %0d",
                         t, id1, v1, (t - 1) % 2);
            end
        end
    endtask

    task automatic test_sole();
        do_reset();
        for (int t = 0; t < 20; t++) begin
            tick(4'b0100);
            checks++;
            if (grant0 !== 4'b0100) begin
                errors++;
                $display("FAIL sole t=%0d got %b want 0100", t, grant0);
            end
        end
        tick(4'b0101);
        checks++;
        if (grant0 !== 4'b0001 || id0 !== 2'd0) begin
            errors++;
            $display("FAIL sole_preempt got g=%b id=%0d want 0001/0",
                     grant0, id0);
        end
    endtask

    task automatic test_release_idle();
        do_reset();
        tick(4'b0010);
        checks++;
        if (grant0 !== 4'b0010 || id0 !== 2'd1) begin
            errors++;
            $display("FAIL rel_own got g=%b id=%0d want 0010/1", grant0, id0);
        end
        req = 4'b0000;
        #1;
        checks++;
        if (any0 !== 1'b0) begin
            errors++;
            $display("FAIL rel_anyreq got %b want 0", any0);
        end
        tick(4'b0000);
        checks++;
        if (grant0 !== 4'b0000 || v0 !== 1'b0 || id0 !== 2'd0) begin
            errors++;
            $display("FAIL rel_idle got g=%b v=%b id=%0d want 0/0/0",
                     grant0, v0, id0);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1;
            m_ptr[d] = 0;
            m_hold[d] = 0;
        end
        r = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                #3;
                rst_n = 1'b0;
                #1;
                checks++;
                if (grant0 !== 4'b0000 || v0 !== 1'b0 ||
                    grant1 !== 4'b0000 || v1 !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_reset n=%0d got %b/%b %b/%b want 0",
                             n, grant0, v0, grant1, v1);
                end
                for (int d = 0; d < 2; d++) begin
                    m_own[d] = -1;
                    m_ptr[d] = 0;
                    m_hold[d] = 0;
                end
                #2;
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 9) < 3) r = 4'($urandom);
            tick(r);
            for (int d = 0; d < 2; d++) begin
                int o = m_own[d];
                int w = -1;
                logic [3:0] ag;
                logic [1:0] aid;
                logic       av;
                logic [3:0] eg;
                if (o < 0) begin
                    w = scan(r, m_ptr[d], -1);
                end else if (!r[o]) begin
                    w = scan(r, m_ptr[d], -1);
                    if (w < 0) begin
                        m_own[d] = -1;
                        m_hold[d] = 0;
                    end
                end else if (m_hold[d] < m_max[d] - 1) begin
                    m_hold[d]++;
                end else begin
                    w = scan(r, (o + 1) % 4, o);
                end
                if (w >= 0) begin
                    m_own[d] = w;
                    m_ptr[d] = (w + 1) % 4;
                    m_hold[d] = 0;
                end
                ag  = (d == 0) ? grant0 : grant1;
                aid = (d == 0) ? id0 : id1;
                av  = (d == 0) ? v0 : v1;
                eg  = (m_own[d] < 0) ? 4'b0000 : 4'(1 << m_own[d]);
                checks++;
                if (ag !== eg || av !== (m_own[d] >= 0) ||
                    aid !== ((m_own[d] < 0) ? 2'd0 : 2'(m_own[d]))) begin
                    errors++;
                    $display("FAIL rnd d%0d n=%0d req=%b got g=%b id=%0d v=%b want g=%b",
                             d, n, r, ag, aid, av, eg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_any_req_sweep();
        test_reset_mid_grant();
        test_round_robin();
        test_preemption();
        test_sole();
        test_release_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with registered one-hot grant and bounded hold time. It shares one downstream resource among four clients and drives that resource's select/enable. The combinational `any_req` output is the 4-input OR of the requests. Grants rotate fairly, and an owner that holds its request too long is preempted when another client is waiting.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the grant while others wait. Legal range is 1..255.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  4: request per client; bit i belongs to client i.
- `grant`  out  4: one-hot grant, registered; 4'b0000 when idle.
- `grant_id`  out  2: index of the granted client, registered; 0 when idle.
- `grant_valid`  out  1: registered; equals the OR of `grant`.
- `any_req`  out  1: combinational OR of `req[3:0]`.

## Operation
- State register: IDLE or OWNED. Also held:
  - `ptr[1:0]`: rotating-priority start index.
  - `hold_cnt`: width $clog2(MAX_HOLD+1).
- Pick function: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and select the first with its `req` bit set.
- IDLE:
  - `any_req`=0: stay in IDLE.
  - `any_req`=1: grant the picked client and go to OWNED. Set ptr = winner+1 (mod 4) and hold_cnt = 0.
- OWNED, owner o, with `req[o]`=0 (release):
  - Pick among the current `req`. A winner gets the grant on the next edge with no idle bubble; apply the ptr/hold_cnt update.
  - No request: go to IDLE and clear the grant.
- OWNED, `req[o]`=1 and hold_cnt < MAX_HOLD-1: keep the grant and increment hold_cnt.
- OWNED, `req[o]`=1 and hold_cnt == MAX_HOLD-1:
  - If any other bit of `req` is set, preempt. Pick starting at o+1 with o excluded, then apply the ptr/hold_cnt update.
  - Otherwise keep o and hold hold_cnt at MAX_HOLD-1, so that o is preempted the moment a competitor appears.
- Only one grant bit may be set. `grant`, `grant_id` and `grant_valid` always change together.
- Requests are level-sensitive. A client that drops `req` before being granted is skipped.

## Timing
- Reset, asserted asynchronously at any time including mid-grant:
  - `grant`=0, `grant_id`=0, `grant_valid`=0.
  - State = IDLE, ptr=0, hold_cnt=0.
  - After `rst_n` deasserts, operation begins at the first rising edge.
- Latency from request to grant is 1 cycle: `req` sampled at edge k produces `grant` visible after edge k.
- Handover on release is 1 cycle. The owner's `req` low at edge k means the new grant appears after edge k, and the old grant is removed on the same edge.
- Preemption: an owner granted after edge g, continuously requesting against a competitor, loses the grant after edge g+MAX_HOLD. It therefore holds the grant for exactly MAX_HOLD cycles.
- When MAX_HOLD=1, every contested cycle rotates the grant.
- `any_req` has zero latency. It is not registered.

## Structure
- Package `arb_pkg` holds:
  - `N_REQ` = 4.
  - `typedef enum logic {IDLE, OWNED} arb_state_t`.
  - `typedef logic [1:0] req_id_t`.
- Sub-module `rr_pick4`: combinational. It takes `req`, `start` and `exclude_en`/`exclude_id`, and returns `found` and `id`. It is instantiated once.
- `any_req` is produced by an instance of the team's `or4`.
- All sequential logic sits in a single `always_ff` with async reset. Next-state logic is in `always_comb`.

## Test plan
- Reset mid-grant: with grant=4'b0100 held, pull `rst_n` low asynchronously between edges. Outputs go to 0 immediately. After release, a request of 4'b1000 is granted client 3 after one edge, showing ptr was reset to 0 and scanning reached 3.
- Round robin: hold `req`=4'b1111 and drop each owner's `req` for one cycle after it has the grant for 1 cycle. The grant sequence is 0,1,2,3,0 with no idle cycles.
- Preemption, MAX_HOLD=8: `req`=4'b0011 held constantly. Client 0 is granted for exactly 8 cycles, then client 1 for 8, then client 0 again.
- Sole requester: `req`=4'b0100 held for 20 cycles. Grant stays 4'b0100 throughout. Raising `req[0]` then moves the grant to client 0 after the next edge.
- Release to idle: sole owner 1 drops `req` so that `req`=0. After the next edge `grant`=0, `grant_valid`=0 and `grant_id`=0. `any_req` is 0 in the same cycle.
- `any_req` sweep: apply all 16 `req` values in IDLE with no clock edges. `any_req`=0 only for 4'b0000.
